// File: rtl/stream_demux_if.sv
// rtl/stream_demux_if.sv - input stream, per-channel output bus and drop counter of stream_demux
//
// Signals:
//   s_valid/s_ready/s_data/s_last/s_sel : input packet stream, s_sel used on first beat only
//   m_valid/m_ready/m_data/m_last        : N_OUT output channels, channel k data at [k*DATA_W +: DATA_W]
//   drop_cnt                             : saturating count of packets dropped for a bad select
// Modports:
//   master : the side that feeds the input stream and consumes the outputs
//   slave  : the demultiplexer itself
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
);
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_W-1:0]       s_data;
    logic                    s_last;
    logic [SEL_W-1:0]        s_sel;
    logic [N_OUT-1:0]        m_valid;
    logic [N_OUT-1:0]        m_ready;
    logic [N_OUT*DATA_W-1:0] m_data;
    logic [N_OUT-1:0]        m_last;
    logic [7:0]              drop_cnt;

    modport master (
        output s_valid, s_data, s_last, s_sel, m_ready,
        input  s_ready, m_valid, m_data, m_last, drop_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, s_sel, m_ready,
        output s_ready, m_valid, m_data, m_last, drop_cnt
    );
endinterface

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-N packet demultiplexer with per-channel register stage and drop counter
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_demux_if.slave (input stream, N_OUT output channels, drop_cnt)
//
// The destination is latched on the first beat of a packet and held until the
// accepted last beat. Each channel owns a single register slot; a slot can be
// refilled on the same edge its current beat is consumed, so a channel with
// m_ready held high sustains one beat per cycle. Packets whose select is not a
// real channel are swallowed whole and counted.
module stream_demux #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    stream_demux_if.slave  bus
);
    localparam int SEL_W = $clog2(N_OUT);
    localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [SEL_W-1:0]              route_q, route_d;
    logic [7:0]                    drop_cnt_q, drop_cnt_d;
    logic [N_OUT-1:0]              valid_q, valid_d;
    logic [N_OUT-1:0]              last_q, last_d;
    logic [N_OUT-1:0][DATA_W-1:0]  data_q, data_d;

    logic                          sel_ok;
    logic                          routing;
    logic [SEL_W-1:0]              tgt;
    logic [N_OUT-1:0]              tgt_oh;
    logic                          ch_free;
    logic                          s_ready;
    logic                          accept;

    // Target decode. The select is widened by one bit so the range check
    // also works when N_OUT is a power of two (every code valid). A one-hot
    // target avoids indexing the channel vectors with an out-of-range select.
    always_comb begin
        sel_ok  = ({1'b0, bus.s_sel} < N_LIM);
        tgt     = (state_q == IDLE) ? bus.s_sel : route_q;
        routing = (state_q == ROUTE) || ((state_q == IDLE) && sel_ok);
        tgt_oh  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            tgt_oh[k] = routing && (tgt == SEL_W'(k));
        end
        // The target slot can take a beat if empty or being drained this edge.
        ch_free = |(tgt_oh & (~valid_q | bus.m_ready));
        s_ready = routing ? ch_free : 1'b1;
        accept  = bus.s_valid && s_ready;
    end

    // Per-channel slots: a load wins over a drain so a same-edge drain and
    // refill leaves the channel valid with the new beat.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (accept && tgt_oh[k]) begin
                valid_d[k] = 1'b1;
                last_d[k]  = bus.s_last;
                data_d[k]  = bus.s_data;
            end else if (bus.m_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Packet FSM: next state, latched route and drop counter.
    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        if (!bus.s_last) begin
                            route_d = bus.s_sel;
                            state_d = ROUTE;
                        end
                    end else begin
                        if (drop_cnt_q != 8'hFF) begin
                            drop_cnt_d = drop_cnt_q + 8'd1;
                        end
                        if (!bus.s_last) begin
                            state_d = DROP;
                        end
                    end
                end
            end
            ROUTE, DROP: begin
                if (accept && bus.s_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            route_q    <= '0;
            drop_cnt_q <= '0;
            valid_q    <= '0;
            last_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            route_q    <= route_d;
            drop_cnt_q <= drop_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = valid_q;
    assign bus.m_last   = last_q;
    assign bus.drop_cnt = drop_cnt_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_flat
        assign bus.m_data[k*DATA_W +: DATA_W] = data_q[k];
    end
endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux (8-channel and 6-channel instances)
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_OUT(8)) if8 ();
    stream_demux_if #(.DATA_W(8), .N_OUT(6)) if6 ();

    stream_demux #(.DATA_W(8), .N_OUT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    stream_demux #(.DATA_W(8), .N_OUT(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       sv;
        logic [2:0] sel;
        logic [7:0] data;
        logic       last;
        logic [7:0] mr;
        logic       exp_srdy;
        logic [7:0] exp_mv;
        int         ch;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic sv, input logic [2:0] sel, input logic [7:0] data,
                                input logic last, input logic [7:0] mr, input logic srdy,
                                input logic [7:0] mv, input int ch, input logic [7:0] ed,
                                input logic el);
        vec_t r;
        r.sv = sv; r.sel = sel; r.data = data; r.last = last; r.mr = mr;
        r.exp_srdy = srdy; r.exp_mv = mv; r.ch = ch; r.exp_data = ed; r.exp_last = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic sv, input logic [2:0] sel, input logic [7:0] data,
                          input logic last, input logic [7:0] mr);
        if8.s_valid = sv; if8.s_sel = sel; if8.s_data = data; if8.s_last = last; if8.m_ready = mr;
    endtask

    task automatic drive6(input logic sv, input logic [2:0] sel, input logic [7:0] data,
                          input logic last, input logic [5:0] mr);
        if6.s_valid = sv; if6.s_sel = sel; if6.s_data = data; if6.s_last = last; if6.m_ready = mr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mv_seen;
        int srdy_bad;

        drive8(0, 0, 0, 0, 8'h00);
        drive6(0, 0, 0, 0, 6'h00);
        rst_n = 1'b0;
        #2;
        chk("reset_mvalid", 32'(if8.m_valid), 32'h0);
        chk("reset_drop", 32'(if8.drop_cnt), 32'h0);
        chk("reset_mdata", 32'(if8.m_data[31:0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First beat of a multi-beat packet to channel 3, left pending.
        drive8(1, 3, 8'h33, 0, 8'h00);
        tick();
        drive8(0, 0, 0, 0, 8'h00);
        chk("pre_rst_mvalid", 32'(if8.m_valid), 32'h08);
        chk("pre_rst_ch3", 32'(if8.m_data[24 +: 8]), 32'h33);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mvalid", 32'(if8.m_valid), 32'h0);
        chk("async_rst_drop", 32'(if8.drop_cnt), 32'h0);
        chk("async_rst_ch3", 32'(if8.m_data[24 +: 8]), 32'h0);
        #2;
        rst_n = 1'b1;
        // Abandoned packet: this beat must be a new first beat to channel 0.
        drive8(1, 0, 8'h5A, 1, 8'h00);
        tick();
        chk("post_rst_mvalid", 32'(if8.m_valid), 32'h01);
        chk("post_rst_ch0", 32'(if8.m_data[0 +: 8]), 32'h5A);
        drive8(0, 0, 0, 0, 8'hFF);
        tick();
        chk("post_rst_drain", 32'(if8.m_valid), 32'h0);

        // Packet lock on channel 5 while s_sel changes.
        tbl.push_back(mk(1, 5, 8'h10, 0, 8'hFF, 1, 8'h20, 5, 8'h10, 0));
        tbl.push_back(mk(1, 0, 8'h11, 0, 8'hFF, 1, 8'h20, 5, 8'h11, 0));
        tbl.push_back(mk(1, 3, 8'h12, 0, 8'hFF, 1, 8'h20, 5, 8'h12, 0));
        tbl.push_back(mk(1, 7, 8'h13, 1, 8'hFF, 1, 8'h20, 5, 8'h13, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 1, 8'h00, 5, 8'h13, 1));
        // Back-to-back single-beat packets across all channels.
        for (int k = 0; k < 8; k++) begin
            tbl.push_back(mk(1, 3'(k), 8'h20 + 8'(k), 1, 8'hFF, 1, 8'(1 << k), k, 8'h20 + 8'(k), 1));
        end
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 1, 8'h00, 7, 8'h27, 1));
        // Backpressure on channel 2, then a packet to channel 4.
        tbl.push_back(mk(1, 2, 8'hA1, 0, 8'hFB, 1, 8'h04, 2, 8'hA1, 0));
        tbl.push_back(mk(1, 4, 8'hA2, 0, 8'hFB, 0, 8'h04, 2, 8'hA1, 0));
        tbl.push_back(mk(1, 4, 8'hA2, 0, 8'hFB, 0, 8'h04, 2, 8'hA1, 0));
        tbl.push_back(mk(1, 4, 8'hA2, 0, 8'hFF, 1, 8'h04, 2, 8'hA2, 0));
        tbl.push_back(mk(1, 4, 8'hA3, 1, 8'hFF, 1, 8'h04, 2, 8'hA3, 1));
        tbl.push_back(mk(1, 4, 8'hB1, 1, 8'hFF, 1, 8'h10, 4, 8'hB1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'hFF, 1, 8'h00, 4, 8'hB1, 1));

        foreach (tbl[i]) begin
            drive8(tbl[i].sv, tbl[i].sel, tbl[i].data, tbl[i].last, tbl[i].mr);
            #1;
            chk($sformatf("v%0d_s_ready", i), 32'(if8.s_ready), 32'(tbl[i].exp_srdy));
            tick();
            chk($sformatf("v%0d_m_valid", i), 32'(if8.m_valid), 32'(tbl[i].exp_mv));
            chk($sformatf("v%0d_m_data", i), 32'(if8.m_data[tbl[i].ch*8 +: 8]), 32'(tbl[i].exp_data));
            chk($sformatf("v%0d_m_last", i), 32'(if8.m_last[tbl[i].ch]), 32'(tbl[i].exp_last));
        end
        drive8(0, 0, 0, 0, 8'hFF);

        // Drop on the 6-channel instance: 3-beat packet with select 7.
        drive6(1, 7, 8'hC1, 0, 6'h00);
        #1;
        chk("drop_b0_s_ready", 32'(if6.s_ready), 32'h1);
        tick();
        chk("drop_b0_mvalid", 32'(if6.m_valid), 32'h0);
        chk("drop_b0_cnt", 32'(if6.drop_cnt), 32'h1);
        drive6(1, 1, 8'hC2, 0, 6'h00);
        #1;
        chk("drop_b1_s_ready", 32'(if6.s_ready), 32'h1);
        tick();
        chk("drop_b1_mvalid", 32'(if6.m_valid), 32'h0);
        drive6(1, 1, 8'hC3, 1, 6'h00);
        #1;
        chk("drop_b2_s_ready", 32'(if6.s_ready), 32'h1);
        tick();
        chk("drop_b2_mvalid", 32'(if6.m_valid), 32'h0);
        chk("drop_b2_cnt", 32'(if6.drop_cnt), 32'h1);
        drive6(1, 1, 8'hD1, 1, 6'h00);
        tick();
        chk("after_drop_mvalid", 32'(if6.m_valid), 32'h02);
        chk("after_drop_ch1", 32'(if6.m_data[8 +: 8]), 32'hD1);
        chk("after_drop_cnt", 32'(if6.drop_cnt), 32'h1);

        // Saturation: 260 single-beat packets to select 6, the first invalid code.
        mv_seen  = 0;
        srdy_bad = 0;
        for (int i = 0; i < 260; i++) begin
            drive6(1, 6, 8'(i), 1, 6'h3F);
            #1;
            if (if6.s_ready !== 1'b1) srdy_bad++;
            tick();
            if (if6.m_valid !== 6'h00) mv_seen++;
            if (i == 252) chk("sat_cnt_254", 32'(if6.drop_cnt), 32'd254);
            if (i == 253) chk("sat_cnt_255", 32'(if6.drop_cnt), 32'd255);
        end
        drive6(0, 0, 0, 0, 6'h3F);
        chk("sat_cnt_final", 32'(if6.drop_cnt), 32'd255);
        chk("sat_no_mvalid", 32'(mv_seen), 32'd0);
        chk("sat_s_ready", 32'(srdy_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised 1-to-N stream demultiplexer for the routing datapath: accepts a valid/ready input stream and steers whole packets to one of N_OUT output channels, selected on the first beat of each packet. Each output has a one-entry register stage, giving full throughput with one cycle of latency. Packets with an out-of-range select are consumed and dropped, and a saturating counter records them.

## Interface
- DATA_W, 8: data width per beat, ≥1.
- N_OUT, 8: number of output channels, 2..16.
- SEL_W, $clog2(N_OUT): select width (derived, not overridden).
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input beat data.
- s_last  in  1  final beat of packet.
- s_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- m_valid  out  N_OUT  per-channel output valid.
- m_ready  in  N_OUT  per-channel output ready.
- m_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- m_last  out  N_OUT  per-channel last flag.
- drop_cnt  out  8  count of dropped packets, saturating at 255.

## Operation
- The FSM has three states:
  - IDLE: awaiting the first beat of a packet.
  - ROUTE: mid-packet to a latched channel `route`.
  - DROP: mid-packet, discarding beats.
- Target channel t: in IDLE, t = s_sel; in ROUTE, t = route; s_sel is ignored outside IDLE.
- s_ready:
  - IDLE with s_sel < N_OUT, or ROUTE: s_ready = !m_valid[t] || m_ready[t].
  - IDLE with s_sel ≥ N_OUT, or DROP: s_ready = 1.
  - s_ready is combinational from m_ready, state and s_sel.
- Accepted beat in IDLE with a valid select:
  - Loads channel s_sel's register (data, last; valid=1).
  - If s_last = 0: route ← s_sel, go to ROUTE. If s_last = 1: stay in IDLE (single-beat packet).
- Accepted beat in ROUTE: loads channel `route`'s register. If s_last = 1, go to IDLE.
- Accepted beat in IDLE with an invalid select:
  - No output is written.
  - drop_cnt increments once per packet, saturating at 255.
  - If s_last = 0, go to DROP; otherwise stay in IDLE.
- DROP: beats are consumed and discarded; an accepted s_last returns the FSM to IDLE.
- Per-channel register k on each edge:
  - Load on the same edge as a handshake targeting k (including when m_ready[k] drains the old beat).
  - Otherwise, clear m_valid[k] when m_ready[k] = 1.
  - Otherwise hold.
- m_data and m_last of a non-valid channel hold their last value; consumers must qualify them with m_valid.
- Channels other than t are never written.
- Other channels drain independently of and concurrently with the input.

## Timing
- Reset (asynchronous, rst_n = 0):
  - m_valid = 0, m_data = 0, m_last = 0, drop_cnt = 0, state = IDLE, route = 0.
  - Takes effect immediately, without waiting for a clock edge.
- Reset mid-packet: the partial packet is abandoned, and the first accepted beat after release is treated as a new packet's first beat.
- Latency: a beat accepted at edge n is visible on m_* after edge n; the earliest consumer handshake is at edge n+1.
- Throughput: one beat per cycle on a channel whose m_ready is held at 1; zero bubbles between back-to-back packets to the same or different channels.
- Backpressure: with m_ready[t] = 0 and m_valid[t] = 1, s_ready = 0; s_data is not sampled.
- Output stability: while m_valid[k] = 1 && m_ready[k] = 0, m_data[k] and m_last[k] hold stable.
- Simultaneous events:
  - Same-edge drain of channel k and a load into k: the new beat wins, and m_valid[k] stays 1.
  - s_last and a new s_sel cannot coincide in one beat; the next packet's select is sampled on the following accepted beat.
- drop_cnt updates on the edge that accepts the dropped packet's first beat.

## Test plan
- Reset check:
  - Stimulus: assert rst_n = 0 asynchronously mid-cycle while channel 3 holds a valid beat.
  - Required: m_valid = 0 immediately, drop_cnt = 0; after release, a 1-beat packet to channel 0 appears on m_valid[0] one cycle later.
- Packet lock:
  - Stimulus: 4-beat packet, s_sel = 5 on beat 0, then s_sel toggles 0..7 on beats 1..3, all m_ready = 1.
  - Required: all 4 beats appear on channel 5 only, in order, with m_last on beat 3.
- Back-to-back switching:
  - Stimulus: single-beat packets to channels 0,1,2,...,7 on consecutive cycles, m_ready all 1.
  - Required: s_ready stays 1 throughout, and each channel shows exactly one beat one cycle after acceptance.
- Backpressure:
  - Stimulus: hold m_ready[2] = 0 while streaming 3 beats (0xA1, 0xA2, 0xA3) to channel 2.
  - Required: m_data[2] = 0xA1 stable, s_ready = 0 after the first beat; once m_ready[2] = 1, beats 0xA2 and 0xA3 follow with no loss or duplication.
  - Stimulus: concurrently send a packet to channel 4 after channel 2's packet.
  - Required: it completes only after channel 2's packet ends.
- Drop: with N_OUT = 6, send a 3-beat packet with s_sel = 7.
  - Required: s_ready = 1 on all beats, no m_valid asserted, drop_cnt = 1, and the next packet to channel 1 is routed normally.
  - Continuing from that state, send 260 invalid-select packets; required: drop_cnt saturates at 255.
